pcie_mwr_bist_mc: RTL

PCIE_MWR_BIST_MC -- requirements
Module: pcie_mwr_bist_mc

---
 rtl/pcie_app_pkg.sv | 26 ++
 rtl/pcie_mwr_bist_link.sv | 115 +++++++++++
 rtl/pcie_mwr_bist_mc.sv | 87 ++++++++
 3 files changed

// File: rtl/pcie_app_pkg.sv
// rtl/pcie_app_pkg.sv - shared types and constants for the PCIe MWr BIST generator
package pcie_app_pkg;

    typedef enum logic [1:0] {
        INC   = 2'd0,
        LFSR  = 2'd1,
        WALK  = 2'd2,
        FIXED = 2'd3
    } bist_pat_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } bist_link_st_e;

    localparam logic [7:0]  HDR_TAG    = 8'hB5;
    localparam logic [31:0] FIXED_WORD = 32'hA5A5A5A5;

    // Fibonacci form of x^32+x^22+x^2+x+1, shifting toward the MSB
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/pcie_mwr_bist_link.sv
// rtl/pcie_mwr_bist_link.sv - one link generator: request/grant FSM plus block pattern source
module pcie_mwr_bist_link
    import pcie_app_pkg::*;
#(
    parameter int LINK_ID = 0,
    parameter int DW      = 256,
    parameter int BEATS   = 128,
    parameter int ITER_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              run_rise,
    input  logic              en,
    input  logic [1:0]        pat_type,
    input  logic [ITER_W-1:0] target,
    input  logic              gnt,
    input  logic              any_valid,
    output logic              req,
    output logic              valid,
    output logic              run_dyn,
    output logic [DW-1:0]     data,
    output logic [ITER_W-1:0] iter
);

    localparam int LANES = DW / 32;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [31:0]    SEED      = 32'(LINK_ID + 1);

    bist_link_st_e     state, next;
    bist_pat_e         pat_q;
    logic [ITER_W-1:0] target_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] iter_inc;
    logic [BCW-1:0]    beat_q;
    logic [31:0]       seq_q;
    logic [31:0]       lfsr_q;
    logic              start;
    logic              last_beat;
    logic              target_hit;

    assign start      = (state == ST_IDLE) && run_rise && en;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign iter_inc   = iter_q + ITER_W'(1);
    assign target_hit = (target_q != '0) && (iter_inc == target_q);
    assign iter       = iter_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next;
    end

    // A run drop during DATA is only honoured at the block boundary
    always_comb begin
        next = state;
        case (state)
            ST_IDLE: if (run_rise && en)          next = ST_REQ;
            ST_REQ:  if (!run)                    next = ST_DONE;
                     else if (gnt && !any_valid)  next = ST_DATA;
            ST_DATA: if (last_beat)               next = (target_hit || !run) ? ST_DONE : ST_REQ;
            ST_DONE: if (!run)                    next = ST_IDLE;
            default:                              next = ST_IDLE;
        endcase
    end

    always_comb begin
        req     = (state == ST_REQ);
        valid   = (state == ST_DATA);
        run_dyn = (state == ST_REQ) || (state == ST_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= INC;
            target_q <= '0;
            iter_q   <= '0;
            beat_q   <= '0;
            seq_q    <= '0;
            lfsr_q   <= SEED;
        end else if (start) begin
            pat_q    <= bist_pat_e'(pat_type);
            target_q <= target;
            iter_q   <= '0;
            beat_q   <= '0;
            seq_q    <= '0;
            lfsr_q   <= SEED;
        end else if (valid) begin
            seq_q  <= seq_q + 32'd1;
            lfsr_q <= lfsr_step(lfsr_q);
            beat_q <= last_beat ? '0 : beat_q + BCW'(1);
            if (last_beat) iter_q <= iter_inc;
        end
    end

    always_comb begin
        logic [31:0] lane;
        data = '0;
        lane = '0;
        if (valid) begin
            for (int l = 0; l < LANES; l++) begin
                case (pat_q)
                    INC:     lane = seq_q * 32'(LANES) + 32'(l);
                    LFSR:    lane = lfsr_q ^ 32'(l);
                    WALK:    lane = 32'd1 << 5'(beat_q);
                    FIXED:   lane = FIXED_WORD;
                    default: lane = '0;
                endcase
                data[l*32 +: 32] = lane;
            end
            if (beat_q == '0) data[31:0] = {HDR_TAG, 8'(LINK_ID), 16'(iter_q)};
        end
    end

endmodule

// File: rtl/pcie_mwr_bist_mc.sv
// rtl/pcie_mwr_bist_mc.sv - multi-link MWr BIST: run edge detect, data merge and error flags
module pcie_mwr_bist_mc
    import pcie_app_pkg::*;
#(
    parameter int LINKS     = 12,
    parameter int DW        = 256,
    parameter int BLK_BYTES = 4096,
    parameter int ITER_W    = 32
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iRUN,
    input  logic [1:0]              iPAT_TYPE,
    input  logic [LINKS-1:0]        iLINK_EN,
    input  logic [ITER_W-1:0]       iITER,
    output logic [LINKS-1:0]        oRUN_DYN,
    output logic [LINKS*ITER_W-1:0] oITER,
    output logic [LINKS-1:0]        oDPLBUF_REQ,
    input  logic [LINKS-1:0]        iDPLBUF_GNT,
    output logic [DW-1:0]           oDPLBUF_DATA,
    output logic [LINKS-1:0]        oDPLBUF_DATA_V,
    output logic [1:0]              oERR
);

    localparam int BEATS = BLK_BYTES * 8 / DW;

    logic             run_q;
    logic             run_rise;
    logic             any_valid_q;
    logic [LINKS-1:0] link_valid;
    logic [DW-1:0]    link_data [LINKS];
    logic [DW-1:0]    merged;
    logic             collision;
    logic             stray_gnt;

    assign run_rise = iRUN && !run_q;

    for (genvar g = 0; g < LINKS; g++) begin : g_link
        pcie_mwr_bist_link #(
            .LINK_ID (g),
            .DW      (DW),
            .BEATS   (BEATS),
            .ITER_W  (ITER_W)
        ) u_link (
            .clk       (iCLK),
            .rst_n     (iRST_N),
            .run       (iRUN),
            .run_rise  (run_rise),
            .en        (iLINK_EN[g]),
            .pat_type  (iPAT_TYPE),
            .target    (iITER),
            .gnt       (iDPLBUF_GNT[g]),
            .any_valid (any_valid_q),
            .req       (oDPLBUF_REQ[g]),
            .valid     (link_valid[g]),
            .run_dyn   (oRUN_DYN[g]),
            .data      (link_data[g]),
            .iter      (oITER[g*ITER_W +: ITER_W])
        );
    end

    // Idle links drive zero, so a plain OR is the bus merge
    always_comb begin
        merged = '0;
        for (int i = 0; i < LINKS; i++) merged = merged | link_data[i];
    end

    assign collision = (link_valid & (link_valid - LINKS'(1))) != '0;
    assign stray_gnt = |(iDPLBUF_GNT & ~oDPLBUF_REQ);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run_q          <= 1'b0;
            any_valid_q    <= 1'b0;
            oDPLBUF_DATA   <= '0;
            oDPLBUF_DATA_V <= '0;
            oERR           <= '0;
        end else begin
            run_q          <= iRUN;
            any_valid_q    <= |link_valid;
            oDPLBUF_DATA   <= merged;
            oDPLBUF_DATA_V <= link_valid;
            oERR           <= (run_rise ? 2'b00 : oERR) | {stray_gnt, collision};
        end
    end

endmodule
